// File: rtl/assoc_data_cache.sv
// assoc_data_cache
//   Fully associative, write-through / no-write-allocate data cache with one
//   word per line. Sits between the load/store stage and backing memory, with
//   a request/response handshake on both sides. Round-robin replacement once
//   every line is valid. Also provides flush and saturating hit/miss counters.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_write/addr/wdata CPU request (accepted when req_ready)
//   req_ready                      high in IDLE while flush is low
//   rsp_valid/rdata/hit            one-cycle response pulse
//   flush                          invalidate all lines, clear counters (IDLE only)
//   mem_valid/mem_write/mem_addr/mem_wdata  backing memory request
//   mem_ready/mem_rdata            backing memory completion / read data
//   hit_count/miss_count           saturating statistics
module assoc_data_cache #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LINES    = 16,
  parameter int OFFSET_W = 3,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  input  logic              flush,
  output logic              mem_valid,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_RD,
    S_MEM_WR
  } state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                lk_hit_q, lk_hit_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [STAT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [STAT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES];

  logic [TAG_W-1:0]    req_tag;
  logic                lk_hit;
  logic [IDX_W-1:0]    lk_idx;
  logic                inv_found;
  logic [IDX_W-1:0]    inv_idx;
  logic [IDX_W-1:0]    victim;

  // Storage write controls produced by the FSM
  logic                fill_en;
  logic                upd_en;

  assign req_tag = addr_q[ADDR_W-1:OFFSET_W];

  // Parallel tag compare; fills only occur on misses, so at most one match.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int unsigned i = 0; i < LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
  end

  // Lowest-index invalid line, else fall back to the round-robin pointer.
  always_comb begin
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int unsigned i = 0; i < LINES; i++) begin
      if (!valid_q[i] && !inv_found) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end
  end

  assign victim = inv_found ? inv_idx : rr_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    rr_d        = rr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    lk_hit_d    = lk_hit_q;
    rsp_valid_d = 1'b0;
    rdata_d     = '0;
    rsp_hit_d   = 1'b0;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    fill_en     = 1'b0;
    upd_en      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          valid_d    = '0;
          hit_cnt_d  = '0;
          miss_cnt_d = '0;
        end else if (req_valid) begin
          addr_d  = addr;
          wdata_d = wdata;
          write_d = req_write;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        lk_hit_d = lk_hit;
        if (lk_hit) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + STAT_W'(1);
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + STAT_W'(1);
        end
        if (write_q) begin
          upd_en  = lk_hit;
          state_d = S_MEM_WR;
        end else if (lk_hit) begin
          rsp_valid_d = 1'b1;
          rdata_d     = data_q[lk_idx];
          rsp_hit_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_MEM_RD;
        end
      end

      S_MEM_RD: begin
        if (mem_ready) begin
          fill_en         = 1'b1;
          valid_d[victim] = 1'b1;
          if (!inv_found) rr_d = rr_q + IDX_W'(1);
          rsp_valid_d     = 1'b1;
          rdata_d         = mem_rdata;
          state_d         = S_IDLE;
        end
      end

      S_MEM_WR: begin
        if (mem_ready) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = lk_hit_q;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      rr_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      lk_hit_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      rsp_hit_q   <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rr_q        <= rr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      lk_hit_q    <= lk_hit_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      rsp_hit_q   <= rsp_hit_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Tag/data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[victim]  <= req_tag;
      data_q[victim] <= mem_rdata;
    end
    if (upd_en) begin
      data_q[lk_idx] <= wdata_q;
    end
  end

  // Memory interface decodes straight from the state register, so an
  // asynchronous reset withdraws the request in the same instant.
  assign mem_valid = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign mem_write = (state_q == S_MEM_WR);
  assign mem_addr  = mem_valid ? addr_q : '0;
  assign mem_wdata = mem_write ? wdata_q : '0;

  assign req_ready  = (state_q == S_IDLE) && !flush;
  assign rsp_valid  = rsp_valid_q;
  assign rdata      = rdata_q;
  assign hit        = rsp_hit_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_assoc_data_cache.sv
module tb_assoc_data_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        hit;
  logic        flush = 1'b0;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  assoc_data_cache #(
    .ADDR_W(32), .DATA_W(32), .LINES(16), .OFFSET_W(3), .STAT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .addr(addr), .wdata(wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rdata(rdata), .hit(hit),
    .flush(flush),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int rsp_seen = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    int          lat;     // 0 = latency not checked
    int          issue;
  } rsp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  rsp_t rsp_q[$];
  mem_t mem_q[$];

  // Backing memory contents, keyed by line (address without offset bits)
  logic [31:0] mem_tbl [logic [28:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_tbl.exists(a[31:3])) return mem_tbl[a[31:3]];
    return {a[15:0] ^ 16'h9E37, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rsp_seen++;
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        chk("rsp_rdata", rdata, e.rdata);
        chk("rsp_hit", {31'd0, hit}, {31'd0, e.hit});
        if (e.lat != 0) chk("rsp_latency", cyc - e.issue, e.lat);
      end
    end
  end

  // Backing memory: completes each request in its third cycle of mem_valid
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        cnt = 0;
      end else if (rst_n && mem_valid) begin
        if (cnt == 2) begin
          if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem: got mem request addr 0x%08h expected none", mem_addr);
          end else begin
            mem_t m;
            m = mem_q.pop_front();
            chk("mem_write", {31'd0, mem_write}, {31'd0, m.write});
            chk("mem_addr", mem_addr, m.addr);
            if (m.write) chk("mem_wdata", mem_wdata, m.wdata);
          end
          if (mem_write) mem_tbl[mem_addr[31:3]] = mem_wdata;
          else           mem_rdata = mem_rd(mem_addr);
          mem_ready = 1'b1;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eh, input int elat,
                       input logic emem);
    int target;
    int n;
    target = rsp_seen + 1;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_write = w;
    addr      = a;
    wdata     = wd;
    rsp_q.push_back('{erd, eh, elat, cyc});
    if (emem) mem_q.push_back('{w, a, wd});
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    n = 0;
    while (rsp_seen < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rsp_seen < target) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no response for addr 0x%08h expected one", a);
    end
  endtask

  task automatic load_miss(input logic [31:0] a);
    issue(1'b0, a, '0, mem_rd(a), 1'b0, 0, 1'b1);
  endtask

  task automatic load_hit(input logic [31:0] a, input logic [31:0] d);
    issue(1'b0, a, '0, d, 1'b1, 2, 1'b0);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    #1 chk("req_ready_flush", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    #1 chk("req_ready_flush2", {31'd0, req_ready}, 32'd0);
    flush = 1'b0;
    #1 chk("req_ready_after_flush", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int n;
    mem_tbl[29'h0000_0202] = 32'hDEAD_BEEF;   // line of 0x1010

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_hit_count", {16'd0, hit_count}, 32'd0);
    chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
    rst_n = 1'b1;

    // 1: cold miss then hit on same line (different offset)
    issue(1'b0, 32'h0000_1010, '0, 32'hDEAD_BEEF, 1'b0, 0, 1'b1);
    chk("t1_miss_count", {16'd0, miss_count}, 32'd1);
    load_hit(32'h0000_1014, 32'hDEAD_BEEF);
    chk("t1_hit_count", {16'd0, hit_count}, 32'd1);

    // 2: store hit writes through and updates the line
    issue(1'b1, 32'h0000_1010, 32'h1234_5678, 32'd0, 1'b1, 0, 1'b1);
    load_hit(32'h0000_1010, 32'h1234_5678);

    // 3: store miss does not allocate
    issue(1'b1, 32'h0000_2000, 32'hCAFE_F00D, 32'd0, 1'b0, 0, 1'b1);
    issue(1'b0, 32'h0000_2000, '0, 32'hCAFE_F00D, 1'b0, 0, 1'b1);
    chk("t3_hit_count", {16'd0, hit_count}, 32'd3);
    chk("t3_miss_count", {16'd0, miss_count}, 32'd3);

    // 5: fill three lines, flush, reload misses
    load_miss(32'h0000_3000);
    load_miss(32'h0000_3008);
    load_miss(32'h0000_3010);
    load_hit(32'h0000_3008, mem_rd(32'h0000_3008));
    do_flush();
    chk("t5_hit_count", {16'd0, hit_count}, 32'd0);
    chk("t5_miss_count", {16'd0, miss_count}, 32'd0);
    load_miss(32'h0000_3008);
    chk("t5_miss_after", {16'd0, miss_count}, 32'd1);

    // 4: fill all 16 lines, then round-robin replacement
    do_flush();
    for (int i = 0; i < 16; i++) load_miss(32'h0000_4000 + 32'(i * 8));
    load_miss(32'h0000_4080);           // evicts line 0 (tag 0x4000), rr -> 1
    load_miss(32'h0000_4000);           // evicts line 1 (tag 0x4008), rr -> 2
    load_hit(32'h0000_4010, mem_rd(32'h0000_4010));
    load_hit(32'h0000_4080, mem_rd(32'h0000_4080));
    load_miss(32'h0000_4008);           // evicts line 2 (tag 0x4010), rr -> 3
    load_hit(32'h0000_4018, mem_rd(32'h0000_4018));
    load_miss(32'h0000_4010);
    chk("t4_hit_count", {16'd0, hit_count}, 32'd3);
    chk("t4_miss_count", {16'd0, miss_count}, 32'd20);

    // 6: reset while a read is outstanding
    @(negedge clk);
    req_valid = 1'b1;
    addr      = 32'h0000_5000;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_mem_valid_seen", {31'd0, mem_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_mem_valid_drop", {31'd0, mem_valid}, 32'd0);
    chk("t6_mem_addr_drop", mem_addr, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t6_rsp_in_reset", {31'd0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    chk("t6_miss_count_rst", {16'd0, miss_count}, 32'd0);
    load_miss(32'h0000_5000);
    chk("t6_miss_count", {16'd0, miss_count}, 32'd1);

    repeat (5) @(negedge clk);
    chk("end_rsp_queue", 32'(rsp_q.size()), 32'd0);
    chk("end_mem_queue", 32'(mem_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

endmodule
